// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 64-bit integer ALU between two requesters.
// A request is accepted with a valid/ready handshake. Arbitration is
// round-robin (RR=1) or fixed priority to requester 0 (RR=0). The operands
// are captured, the ALU result is registered, and the response is held until
// the consumer accepts it. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reqN_valid / reqN_ready       request handshake, N = 0, 1
//   reqN_a, reqN_b                64-bit operands
//   reqN_op                       4-bit ALU opcode
//   rsp_valid / rsp_ready         response handshake
//   rsp_id                        requester that owns the result
//   rsp_result, rsp_zero          ALU result and its zero flag
//   rsp_illegal                   opcode was not a legal code
module alu_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [63:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic        id_q, id_d;
  logic [63:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic        rsp_id_q, rsp_id_d;

  logic        any_valid;
  logic        grant_id;
  logic [63:0] alu_res;
  logic        alu_legal;

  // Arbitration. Under contention round-robin favours the requester that was
  // not granted last; a lone requester always wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = RR ? ~last_grant_q : 1'b0;
    end else begin
      grant_id = ~req0_valid;
    end
  end

  // Readies are gated with rst_n so they stay low throughout reset.
  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant_id;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  grant_id;

  // The shared ALU, driven only by the captured operands.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    unique case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    id_d          = id_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_id_d      = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          a_d          = grant_id ? req1_a  : req0_a;
          b_d          = grant_id ? req1_b  : req0_b;
          op_d         = grant_id ? req1_op : req0_op;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // alu_res is already zero for an illegal op, so zero follows.
        rsp_result_d  = alu_res;
        rsp_zero_d    = (alu_res == '0);
        rsp_illegal_d = ~alu_legal;
        rsp_id_d      = id_q;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      id_q          <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_id_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      id_q          <= id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_id_q      <= rsp_id_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 64-bit integer ALU between two requesters (e.g. the execute stage and a future address/branch unit) with a valid/ready request handshake, round-robin or fixed-priority arbitration, operand capture, and a registered, held response. One operation is in flight at a time. The ALU is instantiated internally and never driven directly by requesters.

## Interface
- RR, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle (handshake = valid & ready).
- req0_a, req0_b / req1_a, req1_b  input  64  operands.
- req0_op / req1_op  input  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100.
- rsp_valid  output  1  result available; held until accepted.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  index of the requester that owns the result.
- rsp_result  output  64  ALU result.
- rsp_zero  output  1  rsp_result == 0.
- rsp_illegal  output  1  op was not one of the five legal codes.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - EXEC: captured operands drive the ALU.
  - RESP: result held.
- IDLE:
  - If any reqX_valid, compute the grant and assert reqX_ready for the granted requester only, combinationally. The ready of the loser stays 0.
  - On the handshake, latch a, b, op and the id. Go to EXEC.
  - With no valid request, stay in IDLE with both readies 0.
- Arbitration with RR=1:
  - When both requesters are valid, grant the requester that was not granted last.
  - The last-grant register updates only on a handshake.
  - Reset value is 1, so requester 0 wins the first contention.
- Arbitration with RR=0: requester 0 wins whenever it is valid.
- A single valid requester is always granted, regardless of history.
- EXEC:
  - Register the ALU output into rsp_result and compute rsp_zero from the registered value.
  - For an illegal op, set rsp_illegal=1, rsp_result=0 and rsp_zero=1.
  - Go to RESP.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_result, rsp_zero and rsp_illegal stable.
  - On rsp_ready, go to IDLE.
  - Both reqX_ready stay 0 in EXEC and in RESP.
- Arithmetic: ADD and SUB wrap modulo 2^64. No carry or overflow output.
  - Examples: 0xFFFF_FFFF_FFFF_FFFF + 1 = 0 with rsp_zero=1; 0 - 1 = 0xFFFF_FFFF_FFFF_FFFF.
- Requesters may change or drop valid while not granted. Operands are sampled only at the handshake edge, and later changes to them have no effect.
- Requesters must not make reqX_valid depend on reqX_ready.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, last_grant=1.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_illegal=0.
  - req0_ready=0 and req1_ready=0 while rst_n=0.
- Latency, with the handshake in cycle 0:
  - EXEC in cycle 1.
  - rsp_valid=1 from cycle 2.
  - If rsp_ready=1 in cycle 2, the FSM is in IDLE in cycle 3, and a new handshake can occur in cycle 3.
- Peak throughput: 1 operation per 3 cycles.
- Backpressure: each cycle with rsp_ready=0 in RESP adds one cycle. Outputs are unchanged during the stall.
- rsp_valid falls in the cycle after the rsp_ready handshake.
- rsp_* registers keep their last values in IDLE and EXEC. Consumers qualify them with rsp_valid.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is dropped, with no response.
  - All outputs return immediately to their reset values.
  - Arbitration restarts with requester 0 favoured.

## Test plan
- Single request: req0 ADD a=5, b=7, valid in cycle 0, rsp_ready=1.
  - req0_ready=1 in cycle 0; rsp_valid=1 in cycle 2.
  - rsp_result=12, rsp_zero=0, rsp_id=0.
  - req0_ready=1 again in cycle 3 if req0 is still valid.
- Contention, RR=1: both requesters valid continuously.
  - req0 SUB 10-10, req1 OR 0xF0|0x0F.
  - Grants alternate 0,1,0,1.
  - Responses: id0 result 0 with zero=1; id1 result 0xFF with zero=0.
- Contention, RR=0: same stimulus.
  - Requester 0 is granted every time.
  - req1_ready stays 0 until req0_valid drops.
- Wrap and illegal op:
  - ADD 0xFFFF_FFFF_FFFF_FFFF+1 -> result 0, zero=1.
  - NOR 0,0 -> result all-ones.
  - op=4'b0111 -> rsp_illegal=1, result 0, zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_* stable and both readies 0 throughout.
  - Release rsp_ready -> IDLE the next cycle; the pending req1 is then granted.
- Reset mid-op: drop rst_n in EXEC.
  - rsp_valid=0 and readies 0 immediately.
  - After release, with both requesters valid, requester 0 is granted first and no stale response appears.
